fifo_level: RTL and testbench

//   Single-clock synchronous FIFO with show-ahead read, empty-bypass tunneling, occupancy count,

---
 rtl/fifo_level.sv | 140 ++++++++++++++
 tb/tb_fifo_level.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_level.sv
// fifo_level: single-clock show-ahead FIFO with empty-bypass tunneling,
// occupancy count, programmable almost-full/almost-empty flags, sticky
// overflow/underflow errors and synchronous flush. Any DEPTH >= 1 is
// supported; pointers wrap by explicit compare rather than masking.
module fifo_level #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 12,
   parameter int AE_THRESH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       wr_en_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       rd_en_i,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       almost_empty_o,
   output logic                       almost_full_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       overflow_o,
   output logic                       underflow_o,
   input  logic                       clr_err_i
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C       = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C       = CW'(AE_THRESH);
   localparam logic [PW-1:0] PTR_LAST_C = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic empty, full;
   logic tunnel;
   logic do_wr, do_rd;
   logic ovf_evt, unf_evt;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST_C) ? '0 : p + PW'(1);
   endfunction

   // Status decode and the set of operations that actually touch storage.
   // A tunneling read+write on an empty FIFO passes data straight through,
   // so it neither stores nor pops.
   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == DEPTH_C);
      tunnel  = empty & wr_en_i & rd_en_i;
      do_rd   = rd_en_i & ~empty;
      do_wr   = wr_en_i & (~full | rd_en_i) & ~tunnel;
      ovf_evt = wr_en_i & full & ~rd_en_i;
      unf_evt = rd_en_i & empty & ~wr_en_i;
   end

   // Next-state for pointers, occupancy and sticky error flags.
   // Flush discards the cycle's traffic and suppresses new errors, but the
   // error-clear path still works independently of it.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         if (clr_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
         end
      end else begin
         if (do_wr) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (do_rd) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (do_wr && !do_rd) begin
            count_d = count_q + CW'(1);
         end else if (do_rd && !do_wr) begin
            count_d = count_q - CW'(1);
         end

         if (clr_err_i) begin
            overflow_d  = ovf_evt;
            underflow_d = unf_evt;
         end else begin
            overflow_d  = overflow_q | ovf_evt;
            underflow_d = underflow_q | unf_evt;
         end
      end
   end

   // Control state registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array; deliberately not reset so it can map onto RAM.
   always_ff @(posedge clk_i) begin
      if (do_wr && !flush_i) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign rd_data_o      = empty ? wr_data_i : mem_q[rd_ptr_q];
   assign empty_o        = empty;
   assign full_o         = full;
   assign almost_empty_o = (count_q <= AE_C);
   assign almost_full_o  = (count_q >= AF_C);
   assign count_o        = count_q;
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: DEPTH=5 and DEPTH=1 instances share one stimulus
// stream and are compared against a queue-based reference model.
module tb_fifo_level;

   logic       clk_i     = 1'b0;
   logic       rst_ni    = 1'b0;
   logic       flush_i   = 1'b0;
   logic       wr_en_i   = 1'b0;
   logic       rd_en_i   = 1'b0;
   logic       clr_err_i = 1'b0;
   logic [7:0] wr_data_i = 8'h00;

   logic [7:0] rd_data5, rd_data1;
   logic       empty5, full5, ae5, af5, ovf5, unf5;
   logic       empty1, full1, ae1, af1, ovf1, unf1;
   logic [2:0] cnt5;
   logic [0:0] cnt1;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] mq [2][$];
   bit         m_ovf [2];
   bit         m_unf [2];
   int         dep  [2] = '{5, 1};
   int         aeth [2] = '{1, 0};
   int         afth [2] = '{4, 1};

   fifo_level #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_d5 (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
      .rd_data_o(rd_data5), .empty_o(empty5), .full_o(full5),
      .almost_empty_o(ae5), .almost_full_o(af5), .count_o(cnt5),
      .overflow_o(ovf5), .underflow_o(unf5), .clr_err_i(clr_err_i));

   fifo_level #(.WIDTH(8), .DEPTH(1), .AF_THRESH(1), .AE_THRESH(0)) u_d1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
      .rd_data_o(rd_data1), .empty_o(empty1), .full_o(full1),
      .almost_empty_o(ae1), .almost_full_o(af1), .count_o(cnt1),
      .overflow_o(ovf1), .underflow_o(unf1), .clr_err_i(clr_err_i));

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input int i, input string tag);
      logic [31:0] o_rd, o_cnt;
      logic        o_e, o_f, o_ae, o_af, o_ov, o_un;
      int          sz;
      logic [31:0] exp_rd;
      sz = mq[i].size();
      if (i == 0) begin
         o_rd = 32'(rd_data5); o_cnt = 32'(cnt5); o_e = empty5; o_f = full5;
         o_ae = ae5; o_af = af5; o_ov = ovf5; o_un = unf5;
      end else begin
         o_rd = 32'(rd_data1); o_cnt = 32'(cnt1); o_e = empty1; o_f = full1;
         o_ae = ae1; o_af = af1; o_ov = ovf1; o_un = unf1;
      end
      exp_rd = (sz == 0) ? 32'(wr_data_i) : 32'(mq[i][0]);
      chk($sformatf("%s/d%0d/rd_data", tag, dep[i]), o_rd, exp_rd);
      chk($sformatf("%s/d%0d/count", tag, dep[i]), o_cnt, 32'(sz));
      chk($sformatf("%s/d%0d/empty", tag, dep[i]), 32'(o_e), 32'(sz == 0));
      chk($sformatf("%s/d%0d/full", tag, dep[i]), 32'(o_f), 32'(sz == dep[i]));
      chk($sformatf("%s/d%0d/almost_empty", tag, dep[i]), 32'(o_ae), 32'(sz <= aeth[i]));
      chk($sformatf("%s/d%0d/almost_full", tag, dep[i]), 32'(o_af), 32'(sz >= afth[i]));
      chk($sformatf("%s/d%0d/overflow", tag, dep[i]), 32'(o_ov), 32'(m_ovf[i]));
      chk($sformatf("%s/d%0d/underflow", tag, dep[i]), 32'(o_un), 32'(m_unf[i]));
   endtask

   // Reference: a FIFO is a queue; pop from the front, push to the back.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int sz;
         bit emp, ful, no, nu;
         sz  = mq[i].size();
         emp = (sz == 0);
         ful = (sz == dep[i]);
         if (flush_i) begin
            mq[i].delete();
            if (clr_err_i) begin
               m_ovf[i] = 1'b0;
               m_unf[i] = 1'b0;
            end
         end else begin
            no = wr_en_i && ful && !rd_en_i;
            nu = rd_en_i && emp && !wr_en_i;
            if (!(emp && wr_en_i && rd_en_i)) begin
               if (rd_en_i && !emp) void'(mq[i].pop_front());
               if (wr_en_i && (!ful || rd_en_i)) mq[i].push_back(wr_data_i);
            end
            if (clr_err_i) begin
               m_ovf[i] = no;
               m_unf[i] = nu;
            end else begin
               m_ovf[i] = m_ovf[i] | no;
               m_unf[i] = m_unf[i] | nu;
            end
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         m_ovf[i] = 1'b0;
         m_unf[i] = 1'b0;
      end
   endtask

   task automatic step(input bit w, input logic [7:0] d, input bit r,
                       input bit fl, input bit clr, input string tag);
      wr_en_i   = w;
      wr_data_i = d;
      rd_en_i   = r;
      flush_i   = fl;
      clr_err_i = clr;
      @(negedge clk_i);
      check_dut(0, tag);
      check_dut(1, tag);
      @(posedge clk_i);
      model_step();
      #1;
   endtask

   logic [7:0] drain_exp [5] = '{8'h12, 8'h13, 8'h14, 8'h15, 8'hFF};

   initial begin
      model_reset();
      #1;
      check_dut(0, "reset");
      check_dut(1, "reset");
      chk("reset_cnt5", 32'(cnt5), 32'd0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // fill to full
      for (int k = 0; k < 5; k++) step(1'b1, 8'h11 + 8'(k), 1'b0, 1'b0, 1'b0, "t1_fill");
      chk("t1_full5", 32'(full5), 32'd1);
      chk("t1_head5", 32'(rd_data5), 32'h11);

      // overflow then clear
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, "t2_ovf");
      chk("t2_ovf5", 32'(ovf5), 32'd1);
      chk("t2_cnt5", 32'(cnt5), 32'd5);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t2_clr");
      chk("t2_clr5", 32'(ovf5), 32'd0);

      // replace while full, then drain across the pointer wrap
      step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "t3_rw");
      chk("t3_cnt5", 32'(cnt5), 32'd5);
      for (int k = 0; k < 5; k++) begin
         chk("t3_drain5", 32'(rd_data5), 32'(drain_exp[k]));
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t3_drain");
      end
      chk("t3_empty5", 32'(empty5), 32'd1);

      // tunneling on empty, then underflow
      step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, "t4_tunnel");
      chk("t4_cnt5", 32'(cnt5), 32'd0);
      chk("t4_nounf5", 32'(unf5), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t4_unf");
      chk("t4_unf5", 32'(unf5), 32'd1);

      // flush with a concurrent write
      for (int k = 0; k < 3; k++) step(1'b1, 8'h30 + 8'(k), 1'b0, 1'b0, 1'b0, "t5_fill");
      step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, "t5_flush");
      chk("t5_cnt5", 32'(cnt5), 32'd0);
      chk("t5_empty5", 32'(empty5), 32'd1);
      chk("t5_noovf5", 32'(ovf5), 32'd0);

      // async reset between edges
      step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, "t6_fill");
      step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, "t6_fill");
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t6_idle");
      #2 rst_ni = 1'b0;
      #1;
      model_reset();
      chk("t6_cnt5", 32'(cnt5), 32'd0);
      chk("t6_empty5", 32'(empty5), 32'd1);
      chk("t6_unf5", 32'(unf5), 32'd0);
      check_dut(0, "t6_rst");
      check_dut(1, "t6_rst");
      rst_ni = 1'b1;

      // random traffic
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
